fetch_bpred: RTL and testbench
==============================

Name: fetch_bpred

Overview:
- Instruction-fetch stage directly upstream of the decode/jump-control path.
- Owns the architectural PC and a direct-mapped table of 2-bit saturating branch counters.
- Predicts B-type branches at fetch and registers the fetched word into the IF/ID pipeline register, together with the predicted-taken bit consumed downstream as flags[16].
- Accepts PC redirects (pc_wr/pc_out) and counter training (branch_taken) from the jump-control stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_BITS, 4, log2 of counter-table entries (16 entries).

Ports:
- clk  input  1  clock, rising-edge.
- nreset  input  1  asynchronous active-low reset.
- ena  input  1  stage enable; 0 = stall, all pipeline state holds.
- imem_addr  output  32  fetch address, equal to current PC (combinational).
- imem_data  input  32  instruction word for imem_addr, valid in the same cycle.
- redirect  input  1  PC write request from jump control (pc_wr).
- redirect_pc  input  32  redirect target (pc_out).
- upd_valid  input  1  resolved conditional branch is in execute this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved outcome (branch_taken).
- if_pc  output  32  registered PC of the fetched instruction.
- if_instr  output  32  registered instruction word.
- if_pred_taken  output  1  registered prediction; feeds flags[16] downstream.
- if_valid  output  1  registered; 0 = bubble.

Behaviour:
- Reset (async, nreset=0):
  - pc = RESET_PC.
  - if_pc = 0, if_instr = 32'h0000_0013 (NOP), if_pred_taken = 0, if_valid = 0.
  - All counters = 2'b01 (weakly not-taken).
  - Reset mid-operation discards everything in flight; the first fetch after release is from RESET_PC.
- Lookup (combinational):
  - idx = pc[BHT_BITS+1:2].
  - is_br = (imem_data[6:0] == 7'b1100011).
  - b_imm = sign-extended {imem_data[31], imem_data[7], imem_data[30:25], imem_data[11:8], 1'b0}.
  - pred = is_br && counter[idx][1].
- Next PC, in priority order, evaluated only when ena=1:
  - redirect=1 → pc <= redirect_pc; if_valid <= 0; the other if_* registers hold. This is a one-cycle flush of the wrong-path word.
  - else pred=1 → pc <= pc + b_imm (32-bit wrap); if_* <= {pc, imem_data, 1, 1}.
  - else → pc <= pc + 4 (wraps 32'hFFFF_FFFC → 0); if_* <= {pc, imem_data, 0, 1}.
- ena=0: pc and all if_* registers hold. redirect is ignored; the upstream block already gates pc_wr with ena.
- Counter update:
  - Applied on every clk edge with upd_valid=1, independent of ena.
  - uidx = upd_pc[BHT_BITS+1:2].
  - upd_taken=1 → saturating increment (11 stays 11).
  - upd_taken=0 → saturating decrement (00 stays 00).
- Same-cycle update and lookup on the same index: lookup sees the pre-update value; the new value is visible from the next cycle (no bypass).
- Latency: instruction at pc appears on if_* one cycle later. Predicted-taken target is fetched with zero bubbles. Mispredict costs exactly one bubble from this stage.
- redirect_pc bit 0 is taken as given; no alignment checks, no exceptions.
- No tag compare: aliasing between PCs that share idx is accepted.

Test Plan:
- Reset, release, ena=1, sequential non-branch words:
  - imem_addr steps 0, 4, 8, C.
  - if_pc lags by one cycle; if_valid=0 in the first cycle after release, then 1.
  - if_pred_taken=0 throughout.
- Train index 2 via upd_pc=32'h8, upd_taken=1 twice → counter 11. Then fetch at pc=8 with imem_data = BEQ with offset +16 (32'h00000863):
  - next imem_addr = 32'h18.
  - if_pred_taken=1, if_pc=8.
- Redirect: redirect=1, redirect_pc=32'h100 while pc=32'h20:
  - next imem_addr = 32'h100; if_valid=0 for one cycle.
  - Following cycle: if_pc=32'h100, if_valid=1.
- Stall: ena=0 for 3 cycles with redirect=1 → pc and if_* unchanged; redirect ignored. An upd_valid pulse in the same window still changes the counter.
- Saturation and collision:
  - Four not-taken updates to upd_pc=32'h4 → counter 00; a fifth stays 00.
  - upd_pc=32'h44 and lookup pc=32'h4 in the same cycle (same idx): the prediction uses the old counter value.
- Async reset asserted mid-stream with pc=32'h30 → outputs take reset values immediately, before the next clk edge. After release, fetch restarts at RESET_PC and all counters read 01 (a BEQ at 0 predicts not-taken).

Source files
------------

// File: rtl/fetch_bpred_if.sv
// Fetch-stage bundle: instruction memory port, jump-control redirect and
// training inputs, and the IF/ID register outputs.
// Modports: slave = the fetch stage itself, master = the surrounding pipeline.
interface fetch_bpred_if;
  logic        ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_pred_taken;
  logic        if_valid;

  modport slave (
    input  ena, imem_data, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
    output imem_addr, if_pc, if_instr, if_pred_taken, if_valid
  );

  modport master (
    output ena, imem_data, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
    input  imem_addr, if_pc, if_instr, if_pred_taken, if_valid
  );
endinterface

// File: rtl/fetch_bpred.sv
// Fetch stage with PC, 2-bit-counter BHT and IF/ID register; predicts B-type branches.
// Latency: word at pc lands on if_* one cycle later; predicted target fetched with no bubble.
// Backpressure: ena=0 freezes pc and if_*; redirect costs one bubble; BHT training ignores ena.
// Ports: clk, nreset (async, active low); bus (slave) carries ena, imem_addr/imem_data,
// redirect/redirect_pc, upd_valid/upd_pc/upd_taken and the registered if_* outputs.
module fetch_bpred #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BHT_BITS = 4
) (
  input  logic         clk,
  input  logic         nreset,
  fetch_bpred_if.slave bus
);

  localparam int          BHT_ENTRIES = 1 << BHT_BITS;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;

  logic [31:0]                  pc;
  logic [31:0]                  if_pc_q;
  logic [31:0]                  if_instr_q;
  logic                         if_pred_q;
  logic                         if_valid_q;
  logic [BHT_ENTRIES-1:0][1:0]  bht;

  logic [BHT_BITS-1:0] idx;
  logic [BHT_BITS-1:0] uidx;
  logic                is_br;
  logic [31:0]         b_imm;
  logic                pred;
  logic [1:0]          upd_cur;
  logic [1:0]          upd_next;

  // Only the index bits of the two PCs address the table; no tags are kept.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:BHT_BITS+2], pc[1:0],
                            bus.upd_pc[31:BHT_BITS+2], bus.upd_pc[1:0]};

  assign idx   = pc[BHT_BITS+1:2];
  assign uidx  = bus.upd_pc[BHT_BITS+1:2];
  assign is_br = (bus.imem_data[6:0] == OP_BRANCH);
  assign b_imm = {{19{bus.imem_data[31]}}, bus.imem_data[31], bus.imem_data[7],
                  bus.imem_data[30:25], bus.imem_data[11:8], 1'b0};
  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign pred  = is_br && bht[idx][1];

  always_comb begin
    upd_cur  = bht[uidx];
    upd_next = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  // PC and IF/ID register. A redirect only kills the slot (if_valid=0);
  // the remaining if_* fields keep their old contents.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc         <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
      if_pred_q  <= 1'b0;
      if_valid_q <= 1'b0;
    end else if (bus.ena) begin
      if (bus.redirect) begin
        pc         <= bus.redirect_pc;
        if_valid_q <= 1'b0;
      end else begin
        pc         <= pred ? (pc + b_imm) : (pc + 32'd4);
        if_pc_q    <= pc;
        if_instr_q <= bus.imem_data;
        if_pred_q  <= pred;
        if_valid_q <= 1'b1;
      end
    end
  end

  // Counter training comes from execute and must not be lost during a stall.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bus.upd_valid) begin
      bht[uidx] <= upd_next;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.if_pc         = if_pc_q;
  assign bus.if_instr      = if_instr_q;
  assign bus.if_pred_taken = if_pred_q;
  assign bus.if_valid      = if_valid_q;

endmodule

// File: tb/tb_fetch_bpred.sv
// Directed bench for fetch_bpred: a behavioural model is checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_fetch_bpred;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI     = 32'h0010_0093;
  localparam logic [31:0] BEQ16    = 32'h0000_0863;

  logic clk;
  logic nreset;
  fetch_bpred_if bus();

  fetch_bpred #(.RESET_PC(RESET_PC), .BHT_BITS(4)) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_if_pc, m_if_instr;
  logic        m_pred, m_vld;
  int          cnt [16];

  function automatic int tbl_index(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic bit model_pred(input logic [31:0] a, input logic [31:0] d);
    return (d[6:0] == 7'h63) && (cnt[tbl_index(a)] >= 2);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [31:0] d);
    int off;
    if (!model_pred(a, d)) return a + 32'd4;
    off = int'({d[31], d[7], d[30:25], d[11:8]});
    if (d[31]) off = off - 4096;
    off = off * 2;
    return a + 32'(off);
  endfunction

  function automatic int train(input int c, input bit taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_pc       <= RESET_PC;
      m_if_pc    <= 32'h0;
      m_if_instr <= NOP;
      m_pred     <= 1'b0;
      m_vld      <= 1'b0;
      for (int i = 0; i < 16; i++) cnt[i] <= 1;
    end else begin
      if (bus.ena && bus.redirect) begin
        m_pc  <= bus.redirect_pc;
        m_vld <= 1'b0;
      end else if (bus.ena) begin
        m_pc       <= model_next(m_pc, bus.imem_data);
        m_if_pc    <= m_pc;
        m_if_instr <= bus.imem_data;
        m_pred     <= model_pred(m_pc, bus.imem_data);
        m_vld      <= 1'b1;
      end
      if (bus.upd_valid)
        cnt[tbl_index(bus.upd_pc)] <= train(cnt[tbl_index(bus.upd_pc)], bus.upd_taken);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_imem_addr", bus.imem_addr, m_pc);
      chk("cyc_if_pc", bus.if_pc, m_if_pc);
      chk("cyc_if_instr", bus.if_instr, m_if_instr);
      chk("cyc_if_pred", 32'(bus.if_pred_taken), 32'(m_pred));
      chk("cyc_if_valid", 32'(bus.if_valid), 32'(m_vld));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ena = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus.upd_valid = 1'b0; bus.upd_pc = 32'h0; bus.upd_taken = 1'b0;
    bus.imem_data = ADDI;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
    chk({tag, "_if_pc"}, bus.if_pc, 32'h0);
    chk({tag, "_if_instr"}, bus.if_instr, NOP);
    chk({tag, "_if_pred"}, 32'(bus.if_pred_taken), 32'h0);
    chk({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
  endtask

  initial begin
    idle();
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #1 chk_reset_vals("reset");
    chk_en = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    #1;
    chk("rel_addr0", bus.imem_addr, 32'h0);
    chk("rel_bubble", 32'(bus.if_valid), 32'h0);

    // Sequential fetch; BEQ at pc=8 with counter 01 falls through.
    step(); chk("seq_addr4", bus.imem_addr, 32'h4); chk("seq_if_pc0", bus.if_pc, 32'h0);
    chk("seq_valid", 32'(bus.if_valid), 32'h1);
    step(); chk("seq_addr8", bus.imem_addr, 32'h8);
    bus.imem_data = BEQ16;
    step(); chk("seq_addrC", bus.imem_addr, 32'hC); chk("beq_wnt_pred", 32'(bus.if_pred_taken), 32'h0);
    bus.imem_data = ADDI;

    // Train index 2 to strongly taken.
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h8; bus.upd_taken = 1'b1;
    step(); step();
    bus.upd_valid = 1'b0;
    chk("train_pc14", bus.imem_addr, 32'h14);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8;
    step(); bus.redirect = 1'b0; bus.imem_data = BEQ16;
    step();
    chk("pred_target", bus.imem_addr, 32'h18);
    chk("pred_taken", 32'(bus.if_pred_taken), 32'h1);
    chk("pred_if_pc", bus.if_pc, 32'h8);
    bus.imem_data = ADDI;
    step(); step();
    chk("at_20", bus.imem_addr, 32'h20);

    // Redirect flush.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    step();
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_bubble", 32'(bus.if_valid), 32'h0);
    bus.redirect = 1'b0;
    step();
    chk("redir_if_pc", bus.if_pc, 32'h100);
    chk("redir_valid", 32'(bus.if_valid), 32'h1);

    // Stall with redirect held; BHT still trains (index 1: 01 -> 10).
    bus.ena = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h200; bus.imem_data = BEQ16;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h4; bus.upd_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.upd_valid = 1'b0;
      chk("stall_addr", bus.imem_addr, 32'h104);
      chk("stall_if_pc", bus.if_pc, 32'h100);
    end
    bus.ena = 1'b1; bus.redirect = 1'b0;
    step();
    chk("stall_trained", bus.imem_addr, 32'h114);
    chk("stall_pred", 32'(bus.if_pred_taken), 32'h1);

    // Saturating decrement on index 1: 10->01->00->00->00.
    bus.imem_data = ADDI;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h4; bus.upd_taken = 1'b0;
    for (int k = 0; k < 5; k++) step();
    bus.upd_taken = 1'b1;                     // 00 -> 01
    bus.redirect = 1'b1; bus.redirect_pc = 32'h4;
    step();
    bus.redirect = 1'b0;
    // Collision: update via 0x44 (01 -> 10) while looking up pc=4 sees 01.
    bus.upd_pc = 32'h44; bus.imem_data = BEQ16;
    step();
    bus.upd_valid = 1'b0;
    chk("coll_addr", bus.imem_addr, 32'h8);
    chk("coll_pred", 32'(bus.if_pred_taken), 32'h0);
    bus.imem_data = ADDI; bus.redirect = 1'b1; bus.redirect_pc = 32'h4;
    step();
    bus.redirect = 1'b0; bus.imem_data = BEQ16;
    step();
    chk("post_coll_addr", bus.imem_addr, 32'h14);
    chk("post_coll_pred", 32'(bus.if_pred_taken), 32'h1);

    // Async reset mid-cycle at pc=0x30.
    bus.imem_data = ADDI; bus.redirect = 1'b1; bus.redirect_pc = 32'h30;
    step();
    bus.redirect = 1'b0;
    chk("at_30", bus.imem_addr, 32'h30);
    #2 nreset = 1'b0;
    #1 chk_reset_vals("async");
    @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    bus.imem_data = BEQ16;
    step();
    chk("rst_addr4", bus.imem_addr, 32'h4);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    step();
    chk("rst_idx1_wnt", bus.imem_addr, 32'h8);
    step();
    chk("rst_idx2_wnt", bus.imem_addr, 32'hC);
    chk("rst_pred", 32'(bus.if_pred_taken), 32'h0);
    idle();
    step(); step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
